// File: rtl/btn_gesture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_gesture_if : debounced button level in, gesture event pulses out
// Revision 1.0
// ---------------------------------------------------------------------------
interface btn_gesture_if;
  logic btn_i;
  logic press_o;
  logic release_o;
  logic click_o;
  logic dbl_click_o;
  logic long_o;
  logic held_o;

  modport master (
    output btn_i,
    input  press_o, release_o, click_o, dbl_click_o, long_o, held_o
  );

  modport slave (
    input  btn_i,
    output press_o, release_o, click_o, dbl_click_o, long_o, held_o
  );
endinterface
`default_nettype wire

// File: rtl/btn_gesture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_gesture : classifies a clean button level into press/release/click/
//               double-click/long-press pulses. Revision 1.0
// ---------------------------------------------------------------------------
module btn_gesture #(
  parameter int unsigned LONG_CYCLES    = 100_000_000,
  parameter int unsigned DBL_GAP_CYCLES = 30_000_000,
  parameter int unsigned CNT_W          = 27
) (
  input  wire logic    clk,
  input  wire logic    n_rst,
  btn_gesture_if.slave bus
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_press1 = 3'd1;
  localparam logic [2:0] c_st_gap    = 3'd2;
  localparam logic [2:0] c_st_press2 = 3'd3;
  localparam logic [2:0] c_st_long   = 3'd4;

  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(DBL_GAP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_d_q, btn_d_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             dbl_q, dbl_d;
  logic             long_q, long_d;
  logic             held_q, held_d;

  logic w_rise;
  logic w_fall;
  logic w_long_to;
  logic w_gap_to;

  // Edges are suppressed until the button has been seen released once.
  assign w_rise    = bus.btn_i & ~btn_d_q & armed_q;
  assign w_fall    = ~bus.btn_i & btn_d_q & armed_q;
  assign w_long_to = (cnt_q == c_long_last);
  assign w_gap_to  = (cnt_q == c_gap_last);

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dbl_d     = 1'b0;
    long_d    = 1'b0;
    btn_d_d   = bus.btn_i;
    armed_d   = armed_q | ~bus.btn_i;

    case (state_q)
      c_st_idle: begin
        if (w_rise) begin
          state_d = c_st_press1;
          press_d = 1'b1;
        end
      end
      c_st_press1: begin
        if (w_fall) begin
          state_d   = c_st_gap;
          release_d = 1'b1;
        end else if (w_long_to) begin
          state_d = c_st_long;
          long_d  = 1'b1;
        end
      end
      c_st_gap: begin
        if (w_rise) begin
          state_d = c_st_press2;
          press_d = 1'b1;
        end else if (w_gap_to) begin
          state_d = c_st_idle;
          click_d = 1'b1;
        end
      end
      c_st_press2: begin
        if (w_fall) begin
          state_d   = c_st_idle;
          release_d = 1'b1;
          dbl_d     = 1'b1;
        end else if (w_long_to) begin
          state_d = c_st_long;
          long_d  = 1'b1;
        end
      end
      c_st_long: begin
        if (w_fall) begin
          state_d   = c_st_idle;
          release_d = 1'b1;
        end
      end
      default: state_d = c_st_idle;
    endcase

    // Counter restarts on every state change and saturates otherwise.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    held_d = (state_d == c_st_long);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= c_st_idle;
      cnt_q     <= '0;
      btn_d_q   <= 1'b0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_d_q   <= btn_d_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dbl_q     <= dbl_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.click_o     = click_q;
  assign bus.dbl_click_o = dbl_q;
  assign bus.long_o      = long_q;
  assign bus.held_o      = held_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_gesture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_gesture : scoreboard bench for btn_gesture with a timestamp model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_btn_gesture;

  localparam int LONG = 20;
  localparam int GAP  = 10;

  typedef struct {
    int         cyc;
    logic [4:0] p;   // {press, release, click, dbl_click, long}
  } exp_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   checks;
  int   errors;
  logic mon_en;
  exp_t exp_q[$];

  // Reference model: gesture tracked as press count plus edge timestamps.
  logic m_prev;
  logic m_armed;
  int   m_presses;
  logic m_down;
  logic m_long;
  int   m_t_press;
  int   m_t_rel;
  logic exp_held;

  btn_gesture_if bus ();

  btn_gesture #(
    .LONG_CYCLES    (LONG),
    .DBL_GAP_CYCLES (GAP),
    .CNT_W          (5)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model(input logic b, input logic r);
    logic [4:0] p;
    logic       rise;
    logic       fall;
    exp_t       e;
    p = '0;
    if (!r) begin
      m_prev    = 1'b0;
      m_armed   = 1'b0;
      m_presses = 0;
      m_down    = 1'b0;
      m_long    = 1'b0;
      exp_held  = 1'b0;
      return;
    end
    rise   = b & ~m_prev & m_armed;
    fall   = ~b & m_prev & m_armed;
    m_prev = b;
    if (!b) m_armed = 1'b1;

    if (rise) begin
      if (m_presses == 0 || (m_presses == 1 && !m_down)) begin
        m_presses = m_presses + 1;
        m_down    = 1'b1;
        m_t_press = cyc;
        p[4]      = 1'b1;
      end
    end else if (fall) begin
      if (m_long) begin
        p[3] = 1'b1;
        m_presses = 0; m_down = 1'b0; m_long = 1'b0;
      end else if (m_presses == 1) begin
        p[3]    = 1'b1;
        m_down  = 1'b0;
        m_t_rel = cyc;
      end else if (m_presses == 2) begin
        p[3] = 1'b1;
        p[1] = 1'b1;
        m_presses = 0; m_down = 1'b0;
      end
    end else begin
      if (m_down && !m_long && (cyc - m_t_press == LONG)) begin
        p[0]   = 1'b1;
        m_long = 1'b1;
      end
      if (!m_down && m_presses == 1 && (cyc - m_t_rel == GAP)) begin
        p[2]      = 1'b1;
        m_presses = 0;
      end
    end
    exp_held = m_long;
    if (p != '0) begin
      e.cyc = cyc;
      e.p   = p;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(input logic b, input logic r);
    bus.btn_i = b;
    n_rst     = r;
    @(posedge clk);
    model(b, r);
    @(negedge clk);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b1);
  endtask

  // Monitor: pops an expected event whenever the DUT shows any pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [4:0] got;
      exp_t       e;
      got = {bus.press_o, bus.release_o, bus.click_o, bus.dbl_click_o, bus.long_o};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc - 1) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: edge %0d got none required %b", e.cyc, e.p);
      end
      if (got != '0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc - 1) begin
          errors++;
          $display("FAIL unexpected_event: edge %0d got %b required 00000", cyc - 1, got);
        end else begin
          e = exp_q.pop_front();
          if (e.p != got) begin
            errors++;
            $display("FAIL event_value: edge %0d got %b required %b", cyc - 1, got, e.p);
          end
        end
      end
      checks++;
      if (bus.held_o !== exp_held) begin
        errors++;
        $display("FAIL held: edge %0d got %b required %b", cyc - 1, bus.held_o, exp_held);
      end
    end
  end

  initial begin
    clk       = 1'b0;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    mon_en    = 1'b1;
    bus.btn_i = 1'b1;
    n_rst     = 1'b0;

    // Held through reset: nothing until a release has been seen.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    hold(1'b1, 8);
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 14);

    // Single click.
    hold(1'b1, 5);
    hold(1'b0, 14);

    // Double click.
    hold(1'b1, 5);
    hold(1'b0, 4);
    hold(1'b1, 5);
    hold(1'b0, 14);

    // Long press, plus a release exactly on the long timeout edge.
    hold(1'b1, 25);
    hold(1'b0, 14);
    hold(1'b1, LONG);
    hold(1'b0, 14);
    hold(1'b1, LONG + 1);
    hold(1'b0, 14);

    // Gap boundary: second rise on the last gap edge, then one edge late.
    hold(1'b1, 5);
    hold(1'b0, GAP);
    hold(1'b1, 5);
    hold(1'b0, 14);
    hold(1'b1, 5);
    hold(1'b0, GAP + 1);
    hold(1'b1, 5);
    hold(1'b0, 14);

    // Double click whose second press becomes a long press.
    hold(1'b1, 3);
    hold(1'b0, 3);
    hold(1'b1, 30);
    hold(1'b0, 14);

    // Reset mid-press abandons the gesture.
    hold(1'b1, 8);
    tick(1'b1, 1'b0);
    hold(1'b1, 6);
    hold(1'b0, 14);
    hold(1'b1, 4);
    hold(1'b0, 14);

    // Randomised level segments, biased towards the timeout boundaries.
    for (int s = 0; s < 200; s++) begin
      int   len;
      logic lvl;
      lvl = s[0];
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(GAP - 1, GAP + 1);
        1:       len = $urandom_range(LONG - 1, LONG + 2);
        default: len = $urandom_range(1, 8);
      endcase
      hold(lvl, len);
      if ($urandom_range(0, 24) == 0) tick(lvl, 1'b0);
    end

    hold(1'b0, 40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
